// File: rtl/priority_distributor.sv
// Steers one valid/ack request stream into per-destination FIFOs.
// A request goes to one destination or, in broadcast mode, to every destination at once.
module priority_distributor #(
  parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_REQUEST                  = 3,
  parameter int unsigned OUTPUT_QUEUE_SIZE            = 2,
  parameter int unsigned NUM_REQUEST_LOG2             = $clog2(NUM_REQUEST)
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_in,
  input  logic [NUM_REQUEST_LOG2-1:0]                         request_dest_in,
  input  logic                                                request_broadcast_in,
  input  logic                                                request_valid_in,
  output logic                                                issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_out,
  output logic [NUM_REQUEST-1:0]                              request_valid_flatted_out,
  input  logic [NUM_REQUEST-1:0]                              issue_ack_flatted_in,
  output logic                                                dest_error_out
);

  localparam int unsigned W     = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int unsigned PTR_W = (OUTPUT_QUEUE_SIZE > 1) ? $clog2(OUTPUT_QUEUE_SIZE) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_REQUEST-1:0] full;
  logic [NUM_REQUEST-1:0] empty;
  logic [NUM_REQUEST-1:0] push;
  logic [NUM_REQUEST-1:0] pop;
  logic [NUM_REQUEST-1:0] dest_onehot;
  logic                   dest_full;
  logic                   dest_in_range;
  logic                   drop_request;

  // Decode the destination and look up its registered full state.
  always_comb begin
    dest_full   = 1'b0;
    dest_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      if (32'(request_dest_in) == i) begin
        dest_full      = full[i];
        dest_onehot[i] = 1'b1;
      end
    end
  end

  assign dest_in_range = (32'(request_dest_in) < NUM_REQUEST);

  // Acceptance only looks at counts registered at the start of the cycle,
  // so a same-cycle pop never frees space for a push.
  always_comb begin
    issue_ack_out = 1'b0;
    push          = '0;
    drop_request  = 1'b0;
    if (!reset_in && request_valid_in) begin
      if (request_broadcast_in) begin
        issue_ack_out = ~|full;
        push          = issue_ack_out ? {NUM_REQUEST{1'b1}} : '0;
      end else if (!dest_in_range) begin
        issue_ack_out = 1'b1;
        drop_request  = 1'b1;
      end else begin
        issue_ack_out = ~dest_full;
        push          = issue_ack_out ? dest_onehot : '0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      dest_error_out <= 1'b0;
    end else if (drop_request) begin
      dest_error_out <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQUEST; g++) begin : g_queue
    logic [W-1:0]     mem [OUTPUT_QUEUE_SIZE];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign full[g]  = (count == CNT_W'(OUTPUT_QUEUE_SIZE));
    assign empty[g] = (count == '0);
    assign pop[g]   = issue_ack_flatted_in[g] & ~empty[g];

    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[g])  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[g], pop[g]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk_in) begin
      if (push[g]) mem[wr_ptr] <= request_in;
    end

    assign request_valid_flatted_out[g]  = ~empty[g];
    assign request_flatted_out[g*W +: W] = empty[g] ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_priority_distributor.sv
// Directed bench for priority_distributor: stimulus pushes expected payloads per
// destination, and a negedge monitor checks every head that gets popped.
module tb_priority_distributor;

  localparam int unsigned W = 64;
  localparam int unsigned N = 3;

  logic           clk_in = 1'b0;
  logic           reset_in;
  logic [W-1:0]   request_in;
  logic [1:0]     request_dest_in;
  logic           request_broadcast_in;
  logic           request_valid_in;
  logic           issue_ack_out;
  logic [W*N-1:0] request_flatted_out;
  logic [N-1:0]   request_valid_flatted_out;
  logic [N-1:0]   issue_ack_flatted_in;
  logic           dest_error_out;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q [N][$];

  priority_distributor #(
    .SINGLE_REQUEST_WIDTH_IN_BITS(W),
    .NUM_REQUEST(N),
    .OUTPUT_QUEUE_SIZE(2)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_in(request_in),
    .request_dest_in(request_dest_in),
    .request_broadcast_in(request_broadcast_in),
    .request_valid_in(request_valid_in),
    .issue_ack_out(issue_ack_out),
    .request_flatted_out(request_flatted_out),
    .request_valid_flatted_out(request_valid_flatted_out),
    .issue_ack_flatted_in(issue_ack_flatted_in),
    .dest_error_out(dest_error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] slice(input int i);
    return request_flatted_out[i*W +: W];
  endfunction

  // Scoreboard monitor: a pop happens at the next edge when valid and ack are both high.
  always @(negedge clk_in) begin
    if (!reset_in) begin
      for (int i = 0; i < N; i++) begin
        if (request_valid_flatted_out[i] && issue_ack_flatted_in[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_pop_q%0d", i), slice(i), '1);
          end else begin
            chk($sformatf("pop_q%0d", i), slice(i), exp_q[i].pop_front());
          end
        end else if (!request_valid_flatted_out[i]) begin
          chk($sformatf("idle_zero_q%0d", i), slice(i), '0);
        end
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the request.
  task automatic send(input logic [W-1:0] d, input int dest, input bit bc, output int waited);
    bit acked = 0;
    request_in           = d;
    request_dest_in      = 2'(dest);
    request_broadcast_in = bc;
    request_valid_in     = 1'b1;
    waited = 0;
    for (int n = 0; n < 20 && !acked; n++) begin
      @(negedge clk_in);
      waited++;
      if (issue_ack_out) begin
        acked = 1;
        if (bc) for (int i = 0; i < N; i++) exp_q[i].push_back(d);
        else if (dest < N) exp_q[dest].push_back(d);
      end
      @(posedge clk_in); #1;
    end
    if (!acked) chk("send_timeout", 64'(waited), 64'(0));
    request_valid_in     = 1'b0;
    request_broadcast_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    int w;
    reset_in             = 1'b1;
    request_in           = '0;
    request_dest_in      = '0;
    request_broadcast_in = 1'b0;
    request_valid_in     = 1'b1;
    issue_ack_flatted_in = '0;
    #12;
    chk("reset_ack_low", 64'(issue_ack_out), 64'(0));
    chk("reset_valid", 64'(request_valid_flatted_out), 64'(0));
    chk("reset_data", request_flatted_out[W-1:0], '0);
    chk("reset_err", 64'(dest_error_out), 64'(0));
    request_valid_in = 1'b0;
    @(negedge clk_in); reset_in = 1'b0;
    tick();

    // Unicast steering with all downstream acks held high
    issue_ack_flatted_in = 3'b111;
    send(64'hA, 0, 0, w);
    @(negedge clk_in);
    chk("uni_valid0", 64'(request_valid_flatted_out), 64'b001);
    chk("uni_data0", slice(0), 64'hA);
    tick();
    send(64'hB, 2, 0, w);
    @(negedge clk_in);
    chk("uni_valid2", 64'(request_valid_flatted_out), 64'b100);
    chk("uni_data2", slice(2), 64'hB);
    tick();
    send(64'hC, 1, 0, w);
    @(negedge clk_in);
    chk("uni_valid1", 64'(request_valid_flatted_out), 64'b010);
    chk("uni_data1", slice(1), 64'hC);
    tick();

    // Back-pressure on a full queue
    issue_ack_flatted_in = 3'b000;
    send(64'h1, 1, 0, w);
    chk("bp_first_wait", 64'(w), 64'(1));
    send(64'h2, 1, 0, w);
    chk("bp_second_wait", 64'(w), 64'(1));
    request_in = 64'h3; request_dest_in = 2'd1; request_valid_in = 1'b1;
    @(negedge clk_in);
    chk("bp_stall", 64'(issue_ack_out), 64'(0));
    tick();
    issue_ack_flatted_in[1] = 1'b1;
    @(negedge clk_in);
    chk("bp_no_same_cycle", 64'(issue_ack_out), 64'(0));
    tick();
    issue_ack_flatted_in[1] = 1'b0;
    @(negedge clk_in);
    chk("bp_ack_after_pop", 64'(issue_ack_out), 64'(1));
    if (issue_ack_out) exp_q[1].push_back(64'h3);
    tick();
    request_valid_in = 1'b0;
    issue_ack_flatted_in[1] = 1'b1;
    repeat (3) tick();
    chk("bp_drained", 64'(request_valid_flatted_out), 64'(0));

    // Broadcast is all-or-nothing
    issue_ack_flatted_in = 3'b000;
    send(64'h10, 0, 0, w);
    send(64'h11, 0, 0, w);
    request_in = 64'hFF; request_dest_in = 2'd0;
    request_broadcast_in = 1'b1; request_valid_in = 1'b1;
    repeat (2) begin
      @(negedge clk_in);
      chk("bc_blocked", 64'(issue_ack_out), 64'(0));
      chk("bc_others_empty", 64'(request_valid_flatted_out[2:1]), 64'(0));
      tick();
    end
    issue_ack_flatted_in[0] = 1'b1;
    @(negedge clk_in);
    chk("bc_blocked_on_pop", 64'(issue_ack_out), 64'(0));
    tick();
    issue_ack_flatted_in[0] = 1'b0;
    @(negedge clk_in);
    chk("bc_ack", 64'(issue_ack_out), 64'(1));
    if (issue_ack_out) for (int i = 0; i < N; i++) exp_q[i].push_back(64'hFF);
    tick();
    request_valid_in = 1'b0; request_broadcast_in = 1'b0;
    @(negedge clk_in);
    chk("bc_all_valid", 64'(request_valid_flatted_out), 64'b111);
    chk("bc_data1", slice(1), 64'hFF);
    chk("bc_data2", slice(2), 64'hFF);
    tick();
    issue_ack_flatted_in = 3'b111;
    repeat (3) tick();

    // Out-of-range destination is acked, dropped and flagged
    request_in = 64'hDEAD; request_dest_in = 2'd3; request_valid_in = 1'b1;
    @(negedge clk_in);
    chk("oor_ack", 64'(issue_ack_out), 64'(1));
    chk("oor_err_not_yet", 64'(dest_error_out), 64'(0));
    tick();
    request_valid_in = 1'b0;
    @(negedge clk_in);
    chk("oor_err_set", 64'(dest_error_out), 64'(1));
    chk("oor_no_valid", 64'(request_valid_flatted_out), 64'(0));
    tick();
    send(64'h55, 2, 0, w);
    @(negedge clk_in);
    chk("oor_err_sticky", 64'(dest_error_out), 64'(1));
    tick();

    // Streaming through queue 0 with continuous pops wraps the pointers
    for (int k = 0; k < 8; k++) begin
      send(64'h100 + 64'(k), 0, 0, w);
      chk("stream_no_stall", 64'(w), 64'(1));
    end
    repeat (2) tick();

    // Asynchronous reset in the middle of a cycle
    issue_ack_flatted_in = 3'b000;
    send(64'h21, 2, 0, w);
    send(64'h22, 2, 0, w);
    @(negedge clk_in);
    chk("rst_pre_valid", 64'(request_valid_flatted_out), 64'b100);
    #2;
    reset_in = 1'b1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    #1;
    chk("rst_valid_now", 64'(request_valid_flatted_out), 64'(0));
    chk("rst_data_now", slice(2), '0);
    chk("rst_err_clear", 64'(dest_error_out), 64'(0));
    @(negedge clk_in); reset_in = 1'b0;
    tick();
    send(64'h77, 2, 0, w);
    chk("rst_first_accept", 64'(w), 64'(1));
    @(negedge clk_in);
    chk("rst_new_valid", 64'(request_valid_flatted_out), 64'b100);
    chk("rst_new_head", slice(2), 64'h77);
    tick();
    issue_ack_flatted_in = 3'b111;
    repeat (2) tick();

    for (int i = 0; i < N; i++)
      chk($sformatf("leftover_q%0d", i), 64'(exp_q[i].size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_distributor.md
# priority_distributor

Single-input, multi-output request distributor. It accepts one request stream under the valid/ack handshake and steers each request, by destination index, into one of NUM_REQUEST per-destination output FIFOs. A broadcast mode copies one request into every destination. It sits on the return path of the cache interconnect, opposite a priority arbiter, and fans responses back to the individual requesters.

## Interface
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width of one request.
- NUM_REQUEST, 3, number of destinations (≥2).
- OUTPUT_QUEUE_SIZE, 2, per-destination FIFO depth; must be a power of 2, ≥2.
- NUM_REQUEST_LOG2 (derived), ceil(log2(NUM_REQUEST)), width of the destination index.
- clk_in, input, 1, clock.
- reset_in, input, 1, reset: asynchronous, active-high.
- request_in, input, SINGLE_REQUEST_WIDTH_IN_BITS, payload.
- request_dest_in, input, NUM_REQUEST_LOG2, destination index; ignored when broadcast is set.
- request_broadcast_in, input, 1, deliver the request to all destinations.
- request_valid_in, input, 1, request present. The upstream holds payload, dest and broadcast stable until acked.
- issue_ack_out, output, 1, request consumed on this clock edge.
- request_flatted_out, output, SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST, slice i = head of queue i.
- request_valid_flatted_out, output, NUM_REQUEST, bit i = queue i non-empty.
- issue_ack_flatted_in, input, NUM_REQUEST, bit i = destination i consumes its head.
- dest_error_out, output, 1, sticky flag: a request with request_dest_in ≥ NUM_REQUEST was dropped.

## Operation
- **Queue structure.** Each destination i has a FIFO of OUTPUT_QUEUE_SIZE entries with:
  - read pointer and write pointer, each log2(OUTPUT_QUEUE_SIZE) bits, wrapping naturally;
  - an occupancy counter of log2(OUTPUT_QUEUE_SIZE)+1 bits;
  - full = (count == OUTPUT_QUEUE_SIZE); empty = (count == 0).
- **Acceptance, unicast.** issue_ack_out = request_valid_in & ~full[request_dest_in]. On the ack edge the entry is written to queue request_dest_in.
- **Acceptance, broadcast.** issue_ack_out = request_valid_in & (no queue full). On the ack edge the entry is written to every queue in the same cycle. Broadcast is all-or-nothing; a partial write is never allowed.
- **Out-of-range destination.** Applies when request_dest_in ≥ NUM_REQUEST and broadcast = 0.
  - issue_ack_out = request_valid_in.
  - Nothing is written to any queue.
  - dest_error_out sets on that edge and stays set until reset.
- **Full-queue acceptance.** Acceptance uses full state registered at the start of the cycle. A full queue does not accept a push even if it is popped in the same cycle. There is no combinational path from issue_ack_flatted_in to issue_ack_out.
- **Output side, per queue i.**
  - request_valid_flatted_out[i] = ~empty[i].
  - request_flatted_out slice i = head entry when valid, otherwise all zeros.
  - A pop occurs when issue_ack_flatted_in[i] & ~empty[i]. An ack on an empty queue is ignored.
- **Simultaneous push and pop** on a non-full, non-empty queue: both pointers advance and the count is unchanged.
- **Count updates:** push-only gives +1, pop-only gives −1, neither or both gives 0.
- **Ordering.** Destinations are independent. A stalled destination blocks the input only when a request targets it, or when a broadcast is pending.

## Timing
- **Reset (asynchronous, immediate):**
  - all pointers and counts go to 0;
  - request_valid_flatted_out = 0;
  - request_flatted_out = 0;
  - dest_error_out = 0;
  - issue_ack_out = 0 while reset_in is high;
  - FIFO storage contents are don't-care.
- **Reset mid-operation:** all queued entries are discarded. The first request after deassertion is accepted in the first cycle where valid is high.
- **Latency:** a request acked on edge k is visible on request_valid_flatted_out at cycle k+1. It can be popped on edge k+1 at the earliest.
- **Throughput:** one request per cycle per input while the target has space.
- **Full queue:** a queue that is full and popped on edge k can accept a push on edge k+1.
- **issue_ack_out** is combinational from request_valid_in, request_dest_in, request_broadcast_in and the registered counts.
- **All other outputs** are functions of registered state only.

## Test plan
- **Unicast steering.** NUM_REQUEST=3, queue size 2. Send payload 0xA to dest 0, 0xB to dest 2, 0xC to dest 1, with all downstream acks held at 1. Each ack is high on the cycle of its request. One cycle later:
  - valid bit 0 shows 0xA;
  - valid bit 2 shows 0xB;
  - valid bit 1 shows 0xC.
- **Back-pressure on a full queue.** Hold issue_ack_flatted_in[1]=0 and send 3 requests to dest 1.
  - First two are acked; third has issue_ack_out=0 and stays stalled.
  - Pulse ack[1]: 0x1 pops. The third request is acked on the following cycle, not the same cycle.
  - Order out is 0x1, 0x2, 0x3.
- **Broadcast all-or-nothing.** Fill queue 0 (2 entries, ack[0]=0), then assert broadcast with 0xFF.
  - issue_ack_out stays 0 and queues 1 and 2 remain empty.
  - Pop one entry from queue 0: broadcast is acked next cycle, and all three queues receive 0xFF together.
- **Out-of-range destination.** dest=3 with NUM_REQUEST=3.
  - issue_ack_out=1, no queue valid rises, dest_error_out=1 from the next cycle.
  - dest_error_out stays 1 through later traffic until reset_in pulses.
- **Concurrent push/pop and wrap-around.** Stream 8 requests to dest 0 with ack[0]=1 continuously.
  - 8 in-order outputs at 1 per cycle, with the count never exceeding 1.
  - Pointers wrap without loss or duplication.
- **Reset mid-operation.** With 2 entries in queue 2, assert reset_in asynchronously mid-cycle.
  - request_valid_flatted_out goes to 0 immediately.
  - After release, a new request to dest 2 appears alone at the head.
